branch_predictor_v2: RTL
========================

# branch_predictor_v2

Next-generation fetch-stage branch predictor, sitting between the PC generator and the fetch buffer. It is parametrised in fetch-group width, BTB depth and tag width. It adds per-entry 2-bit saturating direction counters, first-taken-slot selection across an N-wide fetch group and, optionally, a speculative return address stack. It is filled from decode, trained from execute, and repaired on misprediction.

## Interface
- ADDR_WIDTH, 32, byte address width
- SLOTS, 2, instructions per aligned fetch group (power of 2, 1–8)
- BTB_DEPTH, 32, direct-mapped BTB entries (power of 2)
- TAG_WIDTH, 24, stored tag bits
- RAS_DEPTH, 8, return stack entries (power of 2)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_vld  in  1  lookup request
- if_pc  in  ADDR_WIDTH  fetch PC, word aligned
- id_vld  in  1  decode fill valid
- id_pc / id_tar  in  ADDR_WIDTH  decoded branch PC / target
- id_type  in  2  0 cond, 1 jump, 2 call, 3 return
- ex_vld  in  1  resolved branch valid
- ex_pc / ex_tar  in  ADDR_WIDTH  resolved PC / actual target
- ex_type  in  2  as id_type
- ex_taken  in  1  branch actually taken
- ex_wrong  in  1  misprediction flush
- pd_vld  out  1  prediction valid
- pd_pc  out  ADDR_WIDTH  predicted next fetch PC
- pd_branch  out  1  taken branch predicted
- pd_slot  out  max(1,clog2(SLOTS))  slot causing the branch
- pd_known  out  1  at least one BTB hit in the group

## Operation
- Index = pc[clog2(BTB_DEPTH)+1:2]; tag = next TAG_WIDTH bits above the index.
- Entry: valid, tag, target, type, ctr[1:0]; reset clears all valid bits only.
- Lookup: group base = if_pc with low clog2(SLOTS)+2 bits cleared. Slots k from start slot (if_pc) to SLOTS-1 are read in parallel.
- A slot is taken if it hits and (type≠cond or ctr≥2). The lowest taken slot wins.
- Taken: pd_pc = stored target (or RAS top for a return, see Configuration), pd_branch=1, pd_slot=k.
- None taken: pd_pc = base + SLOTS*4, pd_branch=0, pd_slot=0.
- Fill (id_vld): write the entry unconditionally. ctr = 2 if id_tar<id_pc (backward), else 1.
- Train (ex_vld):
  - Hit: ctr increments if ex_taken and decrements otherwise, saturating at 0/3; target is updated to ex_tar.
  - Miss with ex_taken: allocate with ctr=2.
- Same index written by id and ex in one cycle: ex wins, id write dropped.
- Counter arithmetic is 2-bit saturating, never wraps.

## Timing
- Lookup latency 1 cycle: pd_* registered; pd_vld = if_vld delayed one cycle.
- When pd_vld=0, the other pd_* outputs hold their last values.
- Reset values: pd_vld=0, pd_pc=0, pd_branch=0, pd_slot=0, pd_known=0. The RAS pointers and count are 0.
- BTB writes become visible to lookups the cycle after the write; there is no same-cycle bypass.
- A lookup in the same cycle as ex_wrong still produces a result, but its RAS push/pop is discarded.
- Reset asserted mid-stream: the next cycle has pd_vld=0 and all entries are invalid.

## Configuration
- BRANCH_RAS_EN defined: instantiate the RAS.
  - A predicted-taken call pushes slot PC+4.
  - A predicted-taken return pops and uses the top as pd_pc.
  - Pop on empty: no pop, BTB target used.
  - Push on full: wraps and overwrites the oldest; count saturates at RAS_DEPTH.
  - A commit pointer tracks ex_vld calls/returns; ex_wrong copies commit pointer and count into the speculative ones.
- Undefined: no RAS logic; returns use the BTB target like jumps.

## Structure
- Package branch_pkg: branch type constants (BR_COND, BR_JUMP, BR_CALL, BR_RET), BTB entry struct, counter constants CTR_WEAK_T=2, CTR_WEAK_NT=1.
- Sub-module branch_ras (push, pop, repair, top, empty), instantiated only under BRANCH_RAS_EN.

## Test plan
- Reset, then if_vld with if_pc=0x1000 (SLOTS=2) -> next cycle pd_vld=1, pd_pc=0x1008, pd_branch=0, pd_known=0.
- id fill cond at 0x1004, tar 0x0F00 (backward, ctr=2), then lookup 0x1000 -> pd_pc=0x0F00, pd_branch=1, pd_slot=1.
- Two ex not-taken at 0x1004 (ctr 2→0), then lookup -> pd_pc=0x1008, pd_branch=0, pd_known=1. Third not-taken keeps ctr at 0.
- Jump fills at 0x2000 and 0x2004, lookup 0x2000 -> slot 0 wins. Lookup 0x2004 -> slot 1 wins.
- Same-cycle id and ex writes to one index with different targets -> ex target used on the following lookup.
- BRANCH_RAS_EN:
  - Call at 0x3000 predicted, then return lookup -> pd_pc=0x3004.
  - Nine pushes with RAS_DEPTH=8 -> oldest overwritten.
  - ex_wrong -> speculative pointer equals commit pointer.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and constants for the fetch-stage branch predictor.
// Latency: none (declarations and pure functions only).
// Backpressure: none.
package branch_pkg;

    // Branch type encoding, shared by decode fill and execute training
    localparam logic [1:0] BR_COND = 2'd0;
    localparam logic [1:0] BR_JUMP = 2'd1;
    localparam logic [1:0] BR_CALL = 2'd2;
    localparam logic [1:0] BR_RET  = 2'd3;

    // 2-bit saturating direction counter points
    localparam logic [1:0] CTR_STRONG_NT = 2'd0;
    localparam logic [1:0] CTR_WEAK_NT   = 2'd1;
    localparam logic [1:0] CTR_WEAK_T    = 2'd2;
    localparam logic [1:0] CTR_STRONG_T  = 2'd3;

    // BTB entry control fields. Tag and target are kept in arrays next to
    // this one because their widths are set per predictor instance.
    typedef struct packed {
        logic       valid;
        logic [1:0] btype;
        logic [1:0] ctr;
    } btb_entry_t;

    // Saturating counter step; never wraps past 0 or 3
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_STRONG_T) ? ctr : ctr + 2'd1;
        end
        return (ctr == CTR_STRONG_NT) ? ctr : ctr - 2'd1;
    endfunction

    // Unconditional branches are always taken; conditionals follow the counter
    function automatic logic entry_taken(input btb_entry_t e);
        return (e.btype != BR_COND) || (e.ctr >= CTR_WEAK_T);
    endfunction

endpackage

// File: rtl/branch_ras.sv
// Speculative return address stack with a committed shadow pointer for repair.
// Latency: push/pop/repair take effect the cycle after they are asserted; o_top is combinational.
// Backpressure: none; push on full overwrites the oldest entry, pop on empty is ignored.
module branch_ras
    import branch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int RAS_DEPTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [ADDR_WIDTH-1:0] i_push_dat,
    input  logic                  i_pop,
    input  logic                  i_commit_push,
    input  logic                  i_commit_pop,
    input  logic                  i_repair,
    output logic [ADDR_WIDTH-1:0] o_top,
    output logic                  o_empty
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [ADDR_WIDTH-1:0] r_stack [RAS_DEPTH];
    logic [PTR_W-1:0]      r_sp;
    logic [CNT_W-1:0]      r_cnt;
    logic [PTR_W-1:0]      r_csp;
    logic [CNT_W-1:0]      r_ccnt;
    logic [PTR_W-1:0]      w_csp_nxt;
    logic [CNT_W-1:0]      w_ccnt_nxt;

    // Committed pointer follows resolved calls/returns from execute
    always_comb begin
        w_csp_nxt  = r_csp;
        w_ccnt_nxt = r_ccnt;
        if (i_commit_push) begin
            w_csp_nxt  = r_csp + PTR_W'(1);
            w_ccnt_nxt = (r_ccnt == CNT_MAX) ? r_ccnt : r_ccnt + CNT_W'(1);
        end else if (i_commit_pop && (r_ccnt != '0)) begin
            w_csp_nxt  = r_csp - PTR_W'(1);
            w_ccnt_nxt = r_ccnt - CNT_W'(1);
        end
    end

    // Committed pointer state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_csp  <= '0;
            r_ccnt <= '0;
        end else begin
            r_csp  <= w_csp_nxt;
            r_ccnt <= w_ccnt_nxt;
        end
    end

    // Speculative pointer: repair wins, then push, then pop
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sp  <= '0;
            r_cnt <= '0;
        end else if (i_repair) begin
            r_sp  <= w_csp_nxt;
            r_cnt <= w_ccnt_nxt;
        end else if (i_push) begin
            r_sp  <= r_sp + PTR_W'(1);
            r_cnt <= (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
        end else if (i_pop && (r_cnt != '0)) begin
            r_sp  <= r_sp - PTR_W'(1);
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Return address storage; a full stack simply wraps onto the oldest slot
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_repair && i_push) begin
            r_stack[r_sp] <= i_push_dat;
        end
    end

    assign o_top   = r_stack[r_sp - PTR_W'(1)];
    assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/branch_predictor_v2.sv
// Fetch-stage predictor: direct-mapped BTB with 2-bit counters, first-taken-slot pick; optional RAS under BRANCH_RAS_EN.
// Latency: one cycle from i_if_vld to registered o_pd_*; BTB writes visible to lookups the following cycle.
// Backpressure: none; a lookup is accepted every cycle and o_pd_* hold their last value while o_pd_vld is low.
module branch_predictor_v2
    import branch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int SLOTS      = 2,
    parameter int BTB_DEPTH  = 32,
    parameter int TAG_WIDTH  = 24,
    parameter int RAS_DEPTH  = 8
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst,
    input  logic                                       i_if_vld,
    input  logic [ADDR_WIDTH-1:0]                      i_if_pc,
    input  logic                                       i_id_vld,
    input  logic [ADDR_WIDTH-1:0]                      i_id_pc,
    input  logic [ADDR_WIDTH-1:0]                      i_id_tar,
    input  logic [1:0]                                 i_id_type,
    input  logic                                       i_ex_vld,
    input  logic [ADDR_WIDTH-1:0]                      i_ex_pc,
    input  logic [ADDR_WIDTH-1:0]                      i_ex_tar,
    input  logic [1:0]                                 i_ex_type,
    input  logic                                       i_ex_taken,
    input  logic                                       i_ex_wrong,
    output logic                                       o_pd_vld,
    output logic [ADDR_WIDTH-1:0]                      o_pd_pc,
    output logic                                       o_pd_branch,
    output logic [((SLOTS > 1) ? $clog2(SLOTS) : 1)-1:0] o_pd_slot,
    output logic                                       o_pd_known
);

    localparam int IDX_W  = $clog2(BTB_DEPTH);
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [ADDR_WIDTH-1:0] GRP_MASK  = ADDR_WIDTH'(SLOTS * 4 - 1);
    localparam logic [ADDR_WIDTH-1:0] GRP_BYTES = ADDR_WIDTH'(SLOTS * 4);

    // BTB storage; only the valid bits are reset
    btb_entry_t            r_ent [BTB_DEPTH];
    logic [TAG_WIDTH-1:0]  r_tag [BTB_DEPTH];
    logic [ADDR_WIDTH-1:0] r_tar [BTB_DEPTH];

    // Registered prediction outputs
    logic                  r_pd_vld;
    logic [ADDR_WIDTH-1:0] r_pd_pc;
    logic                  r_pd_branch;
    logic [SLOT_W-1:0]     r_pd_slot;
    logic                  r_pd_known;

    // Lookup datapath
    logic [ADDR_WIDTH-1:0] w_base;
    int                    w_start;
    logic [ADDR_WIDTH-1:0] w_spc;
    logic [IDX_W-1:0]      w_sidx;
    logic                  w_shit;
    logic                  w_known;
    logic                  w_take;
    logic [SLOT_W-1:0]     w_take_slot;
    logic [ADDR_WIDTH-1:0] w_take_tar;
    logic [ADDR_WIDTH-1:0] w_take_pc;
    logic [1:0]            w_take_type;
    logic [ADDR_WIDTH-1:0] w_next_pc;

    // Fill / train datapath
    logic [IDX_W-1:0]      w_id_idx;
    logic [TAG_WIDTH-1:0]  w_id_tag;
    logic [IDX_W-1:0]      w_ex_idx;
    logic [TAG_WIDTH-1:0]  w_ex_tag;
    logic                  w_ex_hit;
    logic                  w_ex_we;
    logic                  w_id_we;
    logic                  w_unused;

    assign w_base  = i_if_pc & ~GRP_MASK;
    assign w_start = int'((i_if_pc >> 2) & ADDR_WIDTH'(SLOTS - 1));

    // Scan the group from the fetch slot upward; the lowest taken slot wins
    always_comb begin
        w_spc       = '0;
        w_sidx      = '0;
        w_shit      = 1'b0;
        w_known     = 1'b0;
        w_take      = 1'b0;
        w_take_slot = '0;
        w_take_tar  = '0;
        w_take_pc   = '0;
        w_take_type = BR_COND;
        for (int k = 0; k < SLOTS; k++) begin
            w_spc  = w_base + ADDR_WIDTH'(4 * k);
            w_sidx = w_spc[IDX_W+1:2];
            w_shit = (k >= w_start) && r_ent[w_sidx].valid &&
                     (r_tag[w_sidx] == w_spc[IDX_W+2 +: TAG_WIDTH]);
            if (w_shit) begin
                w_known = 1'b1;
            end
            if (w_shit && !w_take && entry_taken(r_ent[w_sidx])) begin
                w_take      = 1'b1;
                w_take_slot = SLOT_W'(k);
                w_take_tar  = r_tar[w_sidx];
                w_take_pc   = w_spc;
                w_take_type = r_ent[w_sidx].btype;
            end
        end
    end

`ifdef BRANCH_RAS_EN
    logic                  w_ras_push;
    logic                  w_ras_pop;
    logic                  w_ras_use;
    logic                  w_ras_empty;
    logic [ADDR_WIDTH-1:0] w_ras_top;

    // A lookup that coincides with a flush still predicts but leaves the stack alone
    assign w_ras_use  = w_take && (w_take_type == BR_RET) && !w_ras_empty;
    assign w_ras_pop  = i_if_vld && w_ras_use && !i_ex_wrong;
    assign w_ras_push = i_if_vld && w_take && (w_take_type == BR_CALL) && !i_ex_wrong;

    branch_ras #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAS_DEPTH  (RAS_DEPTH)
    ) u_ras (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_push        (w_ras_push),
        .i_push_dat    (w_take_pc + ADDR_WIDTH'(4)),
        .i_pop         (w_ras_pop),
        .i_commit_push (i_ex_vld && (i_ex_type == BR_CALL)),
        .i_commit_pop  (i_ex_vld && (i_ex_type == BR_RET)),
        .i_repair      (i_ex_wrong),
        .o_top         (w_ras_top),
        .o_empty       (w_ras_empty)
    );

    assign w_next_pc = !w_take   ? (w_base + GRP_BYTES) :
                       w_ras_use ? w_ras_top : w_take_tar;
`else
    // Without a return stack, returns predict through their BTB target like jumps
    assign w_next_pc = w_take ? w_take_tar : (w_base + GRP_BYTES);
`endif

    assign w_id_idx = i_id_pc[IDX_W+1:2];
    assign w_id_tag = i_id_pc[IDX_W+2 +: TAG_WIDTH];
    assign w_ex_idx = i_ex_pc[IDX_W+1:2];
    assign w_ex_tag = i_ex_pc[IDX_W+2 +: TAG_WIDTH];
    assign w_ex_hit = r_ent[w_ex_idx].valid && (r_tag[w_ex_idx] == w_ex_tag);

    // Execute only writes on a hit or a taken miss; when it writes the same
    // index as decode, the resolved information is kept.
    assign w_ex_we = i_ex_vld && (w_ex_hit || i_ex_taken);
    assign w_id_we = i_id_vld && !(w_ex_we && (w_id_idx == w_ex_idx));

    // BTB update: decode fill and execute train/allocate
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                r_ent[i].valid <= 1'b0;
            end
        end else begin
            if (w_id_we) begin
                r_ent[w_id_idx] <= '{valid: 1'b1, btype: i_id_type,
                                     ctr: (i_id_tar < i_id_pc) ? CTR_WEAK_T : CTR_WEAK_NT};
                r_tag[w_id_idx] <= w_id_tag;
                r_tar[w_id_idx] <= i_id_tar;
            end
            if (w_ex_we) begin
                if (w_ex_hit) begin
                    r_ent[w_ex_idx].ctr <= ctr_step(r_ent[w_ex_idx].ctr, i_ex_taken);
                    r_tar[w_ex_idx]     <= i_ex_tar;
                end else begin
                    r_ent[w_ex_idx] <= '{valid: 1'b1, btype: i_ex_type, ctr: CTR_WEAK_T};
                    r_tag[w_ex_idx] <= w_ex_tag;
                    r_tar[w_ex_idx] <= i_ex_tar;
                end
            end
        end
    end

    // Prediction register; payload only moves when a lookup was issued
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pd_vld    <= 1'b0;
            r_pd_pc     <= '0;
            r_pd_branch <= 1'b0;
            r_pd_slot   <= '0;
            r_pd_known  <= 1'b0;
        end else begin
            r_pd_vld <= i_if_vld;
            if (i_if_vld) begin
                r_pd_pc     <= w_next_pc;
                r_pd_branch <= w_take;
                r_pd_slot   <= w_take_slot;
                r_pd_known  <= w_known;
            end
        end
    end

    assign o_pd_vld    = r_pd_vld;
    assign o_pd_pc     = r_pd_pc;
    assign o_pd_branch = r_pd_branch;
    assign o_pd_slot   = r_pd_slot;
    assign o_pd_known  = r_pd_known;

    // Byte-offset and upper address bits are not part of index or tag
    assign w_unused = ^{i_if_pc, i_id_pc, i_ex_pc, i_ex_wrong, w_take_pc};

endmodule
